h14tx_timings_tracker: RTL

H14TX_TIMINGS_TRACKER -- requirements
Module: h14tx_timings_tracker

---
 rtl/h14tx_timings_pkg.sv | 13 +
 rtl/h14tx_sync_edge.sv | 24 ++
 rtl/h14tx_timings_tracker.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/h14tx_timings_pkg.sv
// Shared types for the h14tx raster timing tracker.
// Lock FSM states and the width of the matched-frame counter.
package h14tx_timings_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } lock_state_t;

    localparam int MatchW = 4;

endpackage

// File: rtl/h14tx_sync_edge.sv
// Registers one sync input and flags its rising edge.
// The rise pulse compares the live input with the registered level.
module h14tx_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sync,
    output logic o_level,
    output logic o_rise
);

    logic r_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q <= 1'b0;
        end else begin
            r_q <= i_sync;
        end
    end

    assign o_level = r_q;
    assign o_rise  = i_sync & ~r_q;

endmodule

// File: rtl/h14tx_timings_tracker.sv
// Measures an incoming hsync/vsync/de raster and reports its
// line/frame geometry plus a lock flag once it has been stable.
module h14tx_timings_tracker
    import h14tx_timings_pkg::*;
#(
    parameter int BitWidth   = 11,
    parameter int BitHeight  = 10,
    parameter int LockFrames = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 hsync,
    input  logic                 vsync,
    input  logic                 de,
    output logic [BitWidth-1:0]  x,
    output logic [BitHeight-1:0] y,
    output logic [BitWidth-1:0]  h_total,
    output logic [BitHeight-1:0] v_total,
    output logic [BitWidth-1:0]  h_active,
    output logic [BitHeight-1:0] v_active,
    output logic                 locked,
    output logic                 frame_start
);

    localparam logic [MatchW-1:0] LockCnt = MatchW'(LockFrames);

    logic w_hrise;
    logic w_vrise;
    logic w_unused_hs_q;
    logic w_unused_vs_q;

    h14tx_sync_edge u_hs (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_sync  (hsync),
        .o_level (w_unused_hs_q),
        .o_rise  (w_hrise)
    );

    h14tx_sync_edge u_vs (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_sync  (vsync),
        .o_level (w_unused_vs_q),
        .o_rise  (w_vrise)
    );

    logic [BitWidth-1:0]  r_x;
    logic [BitWidth-1:0]  r_de_cnt;
    logic [BitWidth-1:0]  r_h_total;
    logic [BitWidth-1:0]  r_h_active;
    logic                 r_line_ovf;
    logic                 r_seen_h;
    logic [BitHeight-1:0] r_y;
    logic [BitHeight-1:0] r_act_cnt;
    logic [BitHeight-1:0] r_v_total;
    logic [BitHeight-1:0] r_v_active;
    logic                 r_seen_v;
    logic                 r_frame_bad;
    logic                 r_frame_mism;
    logic                 r_frame_start;
    lock_state_t          r_state;
    logic [MatchW-1:0]    r_match;
    logic                 r_locked;

    logic                 w_x_max;
    logic                 w_y_max;
    logic                 w_line_ovf;
    logic                 w_hcap;
    logic [BitWidth-1:0]  w_h_new;
    logic                 w_h_diff;
    logic                 w_line_act;
    logic [BitHeight-1:0] w_act_inc;
    logic [BitHeight-1:0] w_v_new;
    logic                 w_bad;
    logic                 w_mism;
    logic                 w_frame_ok;
    logic                 w_timeout;
    logic [MatchW-1:0]    w_match_inc;

    assign w_x_max     = (r_x == '1);
    assign w_y_max     = (r_y == '1);
    assign w_line_ovf  = r_line_ovf | w_x_max;
    assign w_hcap      = w_hrise & r_seen_h & ~w_line_ovf;
    assign w_h_new     = r_x + 1'b1;
    assign w_h_diff    = w_hcap & (w_h_new != r_h_total);
    assign w_line_act  = w_hrise & r_seen_h & (r_de_cnt != '0);
    assign w_act_inc   = (w_line_act && r_act_cnt != '1) ? r_act_cnt + 1'b1 : r_act_cnt;
    assign w_v_new     = r_y + 1'b1;
    // Same-cycle hrise events still belong to the frame that vrise closes
    assign w_bad       = r_frame_bad | (w_hrise & r_seen_h & w_line_ovf) | w_y_max;
    assign w_mism      = r_frame_mism | w_h_diff;
    assign w_frame_ok  = ~w_bad & ~w_mism & (w_v_new == r_v_total);
    assign w_timeout   = (w_x_max & ~w_hrise) | (w_y_max & ~w_vrise);
    assign w_match_inc = r_match + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_x        <= '0;
            r_de_cnt   <= '0;
            r_h_total  <= '0;
            r_h_active <= '0;
            r_line_ovf <= 1'b0;
            r_seen_h   <= 1'b0;
        end else begin
            if (w_hrise) begin
                r_x        <= '0;
                r_line_ovf <= 1'b0;
                r_seen_h   <= 1'b1;
                r_de_cnt   <= {{(BitWidth-1){1'b0}}, de};
            end else begin
                if (!w_x_max) r_x <= r_x + 1'b1;
                else          r_line_ovf <= 1'b1;
                if (de && r_de_cnt != '1) r_de_cnt <= r_de_cnt + 1'b1;
            end
            if (w_hcap)     r_h_total  <= w_h_new;
            if (w_line_act) r_h_active <= r_de_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_y           <= '0;
            r_act_cnt     <= '0;
            r_v_total     <= '0;
            r_v_active    <= '0;
            r_seen_v      <= 1'b0;
            r_frame_bad   <= 1'b0;
            r_frame_mism  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_vrise;
            if (w_vrise) begin
                r_y          <= '0;
                r_seen_v     <= 1'b1;
                r_act_cnt    <= '0;
                r_frame_bad  <= 1'b0;
                r_frame_mism <= 1'b0;
                if (r_seen_v) begin
                    r_v_total  <= w_v_new;
                    r_v_active <= w_act_inc;
                end
            end else begin
                if (w_hrise && !w_y_max) r_y <= r_y + 1'b1;
                r_act_cnt    <= w_act_inc;
                r_frame_bad  <= w_bad;
                r_frame_mism <= w_mism;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_SEARCH;
            r_match  <= '0;
            r_locked <= 1'b0;
        end else if (w_timeout) begin
            r_state  <= ST_SEARCH;
            r_match  <= '0;
            r_locked <= 1'b0;
        end else begin
            unique case (r_state)
                ST_SEARCH: begin
                    if (w_vrise) r_state <= ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    if (w_vrise) begin
                        if (!w_frame_ok) begin
                            r_match <= '0;
                        end else if (w_match_inc == LockCnt) begin
                            r_state  <= ST_LOCKED;
                            r_locked <= 1'b1;
                            r_match  <= w_match_inc;
                        end else begin
                            r_match <= w_match_inc;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (w_h_diff || (w_vrise && !w_frame_ok)) begin
                        r_state  <= ST_ACQUIRE;
                        r_match  <= '0;
                        r_locked <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_SEARCH;
                    r_match  <= '0;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    assign x           = r_x;
    assign y           = r_y;
    assign h_total     = r_h_total;
    assign v_total     = r_v_total;
    assign h_active    = r_h_active;
    assign v_active    = r_v_active;
    assign locked      = r_locked;
    assign frame_start = r_frame_start;

endmodule
